// File: rtl/cellram_arbiter.sv
// cellram_arbiter: shares one asynchronous-mode Cellular RAM port between the
// scanout read path and the host write path. Strobe timing is produced by
// cycle counting; reads have priority; every access ends with bus recovery.
// Optional build macro: WR_STARVE_GUARD_EN bounds how many consecutive read
// grants may bypass a waiting write (STARVE_LIMIT).
//
// state | meaning
// IDLE  | bus released, arbitrating requests (read first)
// RD    | CE/OE/LB/UB low; dq_i captured on the last RD cycle
// WR    | CE/WE low, byte lanes from wr_be, latched data driven
// TURN  | all strobes high; write data held through the first cycle
module cellram_arbiter #(
  parameter int ADDR_W       = 26,
  parameter int DATA_W       = 16,
  parameter int RD_CYCLES    = 3,
  parameter int WR_CYCLES    = 3,
  parameter int TURN_CYCLES  = 1,
  parameter int STARVE_LIMIT = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_ack,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [1:0]        wr_be,
  output logic              wr_ack,
  output logic [ADDR_W-1:0] ram_adr,
  input  logic [DATA_W-1:0] dq_i,
  output logic [DATA_W-1:0] dq_o,
  output logic              dq_oe,
  output logic              ram_ce_n,
  output logic              ram_oe_n,
  output logic              ram_we_n,
  output logic              ram_lb_n,
  output logic              ram_ub_n,
  output logic              ram_adv_n,
  output logic              ram_cre,
  output logic              busy
);

  localparam int MAX_A = (RD_CYCLES > WR_CYCLES) ? RD_CYCLES : WR_CYCLES;
  localparam int MAX_C = (MAX_A > TURN_CYCLES) ? MAX_A : TURN_CYCLES;
  localparam int CNT_W = $clog2(MAX_C + 1);
  localparam logic [CNT_W-1:0] RD_LOAD   = CNT_W'(RD_CYCLES - 1);
  localparam logic [CNT_W-1:0] WR_LOAD   = CNT_W'(WR_CYCLES - 1);
  localparam logic [CNT_W-1:0] TURN_LOAD = CNT_W'(TURN_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_TURN} state_t;

  state_t              state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [ADDR_W-1:0]   adr_q;
  logic [DATA_W-1:0]   dqo_q, rdata_q;
  logic                dqoe_q, rd_ack_q, wr_ack_q, rd_valid_q, busy_q;
  logic                ce_n_q, oe_n_q, we_n_q, lb_n_q, ub_n_q;
  logic                grant_rd, grant_wr;

`ifdef WR_STARVE_GUARD_EN
  localparam int STV_W = $clog2(STARVE_LIMIT + 1);
  logic [STV_W-1:0] starve_q;
  logic             starve_hit;

  assign starve_hit = (starve_q == STV_W'(STARVE_LIMIT));
  assign grant_rd   = rd_req && !(starve_hit && wr_req);

  // Count read grants that bypass a waiting write; clear once the write wins or withdraws
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_q <= '0;
    end else if (state_q == S_IDLE) begin
      if (grant_wr || !wr_req) starve_q <= '0;
      else if (grant_rd && !starve_hit) starve_q <= starve_q + 1'b1;
    end
  end
`else
  assign grant_rd = rd_req;
`endif
  assign grant_wr = wr_req && !grant_rd;

  // Access sequencer: arbitration, strobe timing and all registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      adr_q      <= '0;
      dqo_q      <= '0;
      rdata_q    <= '0;
      dqoe_q     <= 1'b0;
      rd_ack_q   <= 1'b0;
      wr_ack_q   <= 1'b0;
      rd_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      ce_n_q     <= 1'b1;
      oe_n_q     <= 1'b1;
      we_n_q     <= 1'b1;
      lb_n_q     <= 1'b1;
      ub_n_q     <= 1'b1;
    end else begin
      rd_ack_q   <= 1'b0;
      wr_ack_q   <= 1'b0;
      rd_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (grant_rd) begin
            state_q  <= S_RD;
            cnt_q    <= RD_LOAD;
            adr_q    <= rd_addr;
            rd_ack_q <= 1'b1;
            busy_q   <= 1'b1;
            ce_n_q   <= 1'b0;
            oe_n_q   <= 1'b0;
            lb_n_q   <= 1'b0;
            ub_n_q   <= 1'b0;
          end else if (grant_wr) begin
            state_q  <= S_WR;
            cnt_q    <= WR_LOAD;
            adr_q    <= wr_addr;
            dqo_q    <= wr_data;
            dqoe_q   <= 1'b1;
            wr_ack_q <= 1'b1;
            busy_q   <= 1'b1;
            ce_n_q   <= 1'b0;
            we_n_q   <= 1'b0;
            lb_n_q   <= ~wr_be[0];
            ub_n_q   <= ~wr_be[1];
          end
        end
        S_RD: begin
          if (cnt_q == '0) begin
            rdata_q    <= dq_i;
            rd_valid_q <= 1'b1;
            state_q    <= S_TURN;
            cnt_q      <= TURN_LOAD;
            ce_n_q     <= 1'b1;
            oe_n_q     <= 1'b1;
            lb_n_q     <= 1'b1;
            ub_n_q     <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        S_WR: begin
          // dq_oe deliberately left high: data hold after WE rises
          if (cnt_q == '0) begin
            state_q <= S_TURN;
            cnt_q   <= TURN_LOAD;
            ce_n_q  <= 1'b1;
            we_n_q  <= 1'b1;
            lb_n_q  <= 1'b1;
            ub_n_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        S_TURN: begin
          dqoe_q <= 1'b0;
          if (cnt_q == '0) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign rd_ack    = rd_ack_q;
  assign wr_ack    = wr_ack_q;
  assign rd_valid  = rd_valid_q;
  assign rd_data   = rdata_q;
  assign ram_adr   = adr_q;
  assign dq_o      = dqo_q;
  assign dq_oe     = dqoe_q;
  assign ram_ce_n  = ce_n_q;
  assign ram_oe_n  = oe_n_q;
  assign ram_we_n  = we_n_q;
  assign ram_lb_n  = lb_n_q;
  assign ram_ub_n  = ub_n_q;
  assign ram_adv_n = 1'b0;
  assign ram_cre   = 1'b0;
  assign busy      = busy_q;

endmodule
